// File: rtl/lvds_tx.sv
// lvds_tx - transmit-side serialiser for the modem LVDS I/Q link.
//
// Pulls one 32-bit I/Q word from the TX FIFO every 16 clocks. It shifts the
// word out MSB-first, two bits per clock, to an external DDR output buffer.
// Word layout: [31:30] I sync (10), [29:17] I, [16] I ctrl,
//              [15:14] Q sync (01), [13:1]  Q, [0]  Q ctrl.
//
// Ports:
//   i_ddr_clk       modem TX DDR clock (only clock)
//   i_rst_b         asynchronous active-low reset
//   i_tx_enable     transmit enable, sampled only at frame count 14
//   i_fifo_empty    TX FIFO empty flag
//   i_fifo_data     TX FIFO read data, valid the cycle after o_fifo_pull
//   o_fifo_pull     one-cycle FIFO read strobe (frame count 14 only)
//   o_ddr_data      bit pair; [1] goes out on the rising edge, [0] on falling
//   o_frame_start   high while the first pair of a word is on o_ddr_data
//   o_active        high while in the ACTIVE state
//   i_underrun_clr  synchronous clear of the underrun flag and counter
//   o_underrun      sticky underrun flag
//   o_underrun_cnt  saturating underrun event count
module lvds_tx #(
  parameter logic [31:0] IDLE_WORD  = 32'h8000_4000,
  parameter bit          FORCE_SYNC = 1'b1
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst_b,
  input  logic        i_tx_enable,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pull,
  output logic [1:0]  o_ddr_data,
  output logic        o_frame_start,
  output logic        o_active,
  input  logic        i_underrun_clr,
  output logic        o_underrun,
  output logic [15:0] o_underrun_cnt
);

  typedef enum logic {DISABLED, ACTIVE} state_t;

  // Source of the next word, decided at count 14 and consumed at count 15.
  typedef enum logic [1:0] {SRC_ZERO, SRC_FIFO, SRC_IDLE} src_t;

  logic [3:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic [31:0] shift_q, shift_d;
  logic        frameStart_q, frameStart_d;
  logic        underrun_q, underrun_d;
  logic [15:0] underrunCnt_q, underrunCnt_d;
  logic [31:0] nextWord;
  logic        underrunEvent;

  // All state lives in one register bank. A reset discards any word that is
  // part-way through being sent.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cnt_q         <= 4'd0;
      state_q       <= DISABLED;
      src_q         <= SRC_ZERO;
      shift_q       <= 32'd0;
      frameStart_q  <= 1'b0;
      underrun_q    <= 1'b0;
      underrunCnt_q <= 16'd0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      src_q         <= src_d;
      shift_q       <= shift_d;
      frameStart_q  <= frameStart_d;
      underrun_q    <= underrun_d;
      underrunCnt_q <= underrunCnt_d;
    end
  end

  // Frame decision at count 14. This is the only point where enable and
  // FIFO empty are looked at. Any change elsewhere in the frame waits for
  // the next boundary, so a word always goes out complete.
  always_comb begin
    cnt_d         = cnt_q + 4'd1;
    state_d       = state_q;
    src_d         = src_q;
    o_fifo_pull   = 1'b0;
    underrunEvent = 1'b0;
    if (cnt_q == 4'd14) begin
      if (i_tx_enable) begin
        state_d = ACTIVE;
        if (i_fifo_empty) begin
          src_d         = SRC_IDLE;
          underrunEvent = 1'b1;
        end else begin
          src_d       = SRC_FIFO;
          o_fifo_pull = 1'b1;
        end
      end else begin
        state_d = DISABLED;
        src_d   = SRC_ZERO;
      end
    end
  end

  // Select the next word at count 15, when the pulled FIFO data is valid.
  // Forcing the sync fields keeps the receiver framed even if software
  // writes raw samples.
  always_comb begin
    nextWord = 32'd0;
    case (src_q)
      SRC_FIFO: begin
        nextWord = i_fifo_data;
        if (FORCE_SYNC) begin
          nextWord[31:30] = 2'b10;
          nextWord[15:14] = 2'b01;
        end
      end
      SRC_IDLE: nextWord = IDLE_WORD;
      default:  nextWord = 32'd0;
    endcase
  end

  // The shift register loads on the 15 -> 0 edge and shifts two bits per
  // clock. Its top two bits drive the output pair directly, so the pair is
  // registered with no extra stage. The frame-start flag is registered for
  // the same reason and lines up with count 0.
  always_comb begin
    shift_d      = (cnt_q == 4'd15) ? nextWord : {shift_q[29:0], 2'b00};
    frameStart_d = (cnt_q == 4'd15);
  end

  // Underrun bookkeeping. An event in the same cycle as a clear takes
  // precedence, so the count restarts at 1 and does not lose that event.
  always_comb begin
    underrun_d    = underrun_q;
    underrunCnt_d = underrunCnt_q;
    if (underrunEvent) begin
      underrun_d = 1'b1;
      if (i_underrun_clr) begin
        underrunCnt_d = 16'd1;
      end else if (underrunCnt_q != 16'hFFFF) begin
        underrunCnt_d = underrunCnt_q + 16'd1;
      end
    end else if (i_underrun_clr) begin
      underrun_d    = 1'b0;
      underrunCnt_d = 16'd0;
    end
  end

  assign o_ddr_data     = shift_q[31:30];
  assign o_frame_start  = frameStart_q;
  assign o_active       = (state_q == ACTIVE);
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = underrunCnt_q;

endmodule
